// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared register-file widths and the write-request record
package cpu_defs;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  localparam int WR_REQ_W = $bits(wr_req_t);

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_write_sched_fifo.sv
// rtl/regfile_write_sched_fifo.sv - circular FIFO that also exposes every slot for occupancy scans
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [CW-1:0]          count,
  output logic [DEPTH-1:0]       entry_valid,
  output logic [DEPTH*WIDTH-1:0] entries
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    entry_valid = '0;
    entries     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i]              = ({1'b0, AW'(i) - rd_ptr_q} < count_q);
      entries[i*WIDTH +: WIDTH]   = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/regfile_write_sched.sv
// rtl/regfile_write_sched.sv - shares the register-file write port between writeback and a buffered multi-cycle unit
module regfile_write_sched
  import cpu_defs::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_addr,
  input  logic [DATA_W-1:0]     mc_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0]     rf_wd3,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  starve,
  output logic [CW-1:0]         fifo_count
);

  wr_req_t                   mc_req, head;
  logic                      fifo_full, fifo_empty;
  logic [DEPTH-1:0]          entry_valid;
  logic [DEPTH*WR_REQ_W-1:0] entries;
  logic                      wb_fire, pop, push;
  logic [7:0]                starve_cnt_q, starve_cnt_d;
  logic                      starve_q, starve_d;

  assign mc_req = '{addr: mc_addr, data: mc_data};

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WR_REQ_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .din        (mc_req),
    .pop        (pop),
    .dout       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .entry_valid(entry_valid),
    .entries    (entries)
  );

  // Writes to r0 count as idle so the FIFO can drain underneath them.
  always_comb begin
    wb_fire  = wb_we && (wb_addr != REG_ZERO);
    pop      = !rst && !wb_fire && !fifo_empty && (head.addr != REG_ZERO);
    mc_ready = !rst && !fifo_full;
    push     = mc_valid && mc_ready && (mc_addr != REG_ZERO);
    rf_we    = !rst && (wb_fire || pop);
    rf_a3    = wb_fire ? wb_addr : head.addr;
    rf_wd3   = wb_fire ? wb_data : head.data;
  end

  // Address field sits in the upper bits of each packed request.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending = pending | reg_onehot(entries[i*WR_REQ_W + DATA_W +: REG_ADDR_W]);
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (wb_fire && (starve_cnt_q != 8'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
    starve_d = (starve_cnt_d == 8'(STARVE_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign starve = starve_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// tb/tb_regfile_write_sched.sv - directed and random checks of the write-port scheduler against a queue model
module tb_regfile_write_sched;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst, wb_we, mc_valid, mc_ready, rf_we, starve;
  logic [4:0]  wb_addr, mc_addr, rf_a3;
  logic [31:0] wb_data, mc_data, rf_wd3, pending;
  logic [2:0]  fifo_count;

  req_t q[$];
  int   bcnt = 0;
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_write_sched #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .mc_valid  (mc_valid),
    .mc_ready  (mc_ready),
    .mc_addr   (mc_addr),
    .mc_data   (mc_data),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .pending   (pending),
    .starve    (starve),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the queue model, advance the model, step the clock.
  task automatic cycle(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic v, input logic [4:0] ma, input logic [31:0] md, output logic acc);
    logic        e_ready, fire, e_we, popm, was_empty;
    logic [31:0] e_pend;
    req_t        nr;
    rst = r; wb_we = we; wb_addr = wa; wb_data = wd;
    mc_valid = v; mc_addr = ma; mc_data = md;
    #3;
    n_vec++;
    e_ready = !r && (q.size() < DEPTH);
    fire    = we && (wa != 5'd0);
    e_we    = !r && (fire || q.size() > 0);
    e_pend  = 32'd0;
    foreach (q[k]) e_pend[q[k].addr] = 1'b1;
    check("mc_ready", mc_ready, e_ready);
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_a3", rf_a3, fire ? wa : q[0].addr);
      check("rf_wd3", rf_wd3, fire ? wd : q[0].data);
    end
    check("pending", pending, e_pend);
    check("fifo_count", fifo_count, q.size());
    check("starve", starve, bcnt >= SMAX);
    acc = e_ready && v;
    if (r) begin
      q.delete();
      bcnt = 0;
    end else begin
      was_empty = (q.size() == 0);
      popm      = !fire && !was_empty;
      if (popm) void'(q.pop_front());
      if (acc && ma != 5'd0) begin
        nr.addr = ma; nr.data = md;
        q.push_back(nr);
      end
      bcnt = (popm || was_empty) ? 0 : bcnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        a;
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    rst = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
    @(posedge clk);
    #1;

    // Reset then idle
    cycle(1, 0, 0, 0, 0, 0, 0, a);
    cycle(1, 0, 0, 0, 1, 5, 32'h55, a);
    cycle(0, 0, 0, 0, 0, 0, 0, a);
    cycle(0, 0, 0, 0, 0, 0, 0, a);

    // Writeback priority over a queued result
    cycle(0, 1, 3, 32'h11, 1, 5, 32'hAA, a);
    for (int i = 0; i < 3; i++) cycle(0, 1, 3, 32'h11, 0, 0, 0, a);
    check("wbprio_pending5", pending[5], 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, a);
    cycle(0, 0, 0, 0, 0, 0, 0, a);

    // Fill and backpressure
    for (int i = 1; i <= 4; i++) cycle(0, 1, 1, 32'h22, 1, 5'(i), 32'h100 + i, a);
    check("fill_count", fifo_count, 3'd4);
    cycle(0, 1, 1, 32'h22, 1, 9, 32'h999, a);
    cycle(0, 1, 1, 32'h22, 1, 9, 32'h999, a);
    cycle(0, 0, 0, 0, 1, 9, 32'h999, a);
    cycle(0, 0, 0, 0, 1, 9, 32'h999, a);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0, a);

    // Zero register on both producers
    cycle(0, 1, 2, 32'h33, 1, 6, 32'h66, a);
    cycle(0, 1, 0, 32'h44, 0, 0, 0, a);
    cycle(0, 0, 0, 0, 1, 0, 32'h77, a);
    cycle(0, 0, 0, 0, 0, 0, 0, a);

    // Starvation
    cycle(0, 1, 7, 32'h70, 1, 8, 32'h88, a);
    for (int i = 0; i < SMAX; i++) cycle(0, 1, 7, 32'h70, 0, 0, 0, a);
    check("starve_hold", starve, 1'b1);
    cycle(0, 1, 7, 32'h70, 0, 0, 0, a);
    cycle(0, 0, 0, 0, 0, 0, 0, a);
    cycle(0, 0, 0, 0, 0, 0, 0, a);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) cycle(0, 1, 4, 32'h40, 1, 5'(10 + i), 32'hB0 + i, a);
    cycle(1, 0, 0, 0, 0, 0, 0, a);
    check("midrst_count", fifo_count, 3'd0);
    check("midrst_pending", pending, 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, a);

    // Random traffic with a producer that holds its request until accepted
    pv = 1'b0; pa = '0; pd = '0;
    for (int i = 0; i < 600; i++) begin
      logic        r, we;
      logic [4:0]  wa;
      if (!pv && $urandom_range(0, 2) == 0) begin
        pv = 1'b1;
        pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pd = $urandom;
      end
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 9) < 6);
      wa = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(r, we, wa, $urandom, pv, pa, pd, a);
      if (a) pv = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
